// File: rtl/pzcorebus_pkg.sv
// Shared definitions for the pzcorebus protocol monitor: error codes and helpers.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package pzcorebus_pkg;

    // Error codes double as bit positions in the monitor's sticky error vector.
    typedef enum logic [2:0] {
        PZCOREBUS_MCMD_UNSTABLE        = 3'd0,
        PZCOREBUS_MDATA_UNSTABLE       = 3'd1,
        PZCOREBUS_BURST_MISMATCH       = 3'd2,
        PZCOREBUS_SRESP_UNSTABLE       = 3'd3,
        PZCOREBUS_SRESP_UNKNOWN        = 3'd4,
        PZCOREBUS_OUTSTANDING_OVERFLOW = 3'd5,
        PZCOREBUS_FIFO_OVERFLOW        = 3'd6
    } pzcorebus_monitor_error;

    localparam int PZCOREBUS_MONITOR_ERROR_NUM = 7;

    // Lowest set bit wins when several errors fire in the same cycle.
    function automatic logic [2:0] first_error_code(
        input logic [PZCOREBUS_MONITOR_ERROR_NUM-1:0] err
    );
        first_error_code = 3'd0;
        for (int i = PZCOREBUS_MONITOR_ERROR_NUM - 1; i >= 0; i--) begin
            if (err[i]) begin
                first_error_code = 3'(i);
            end
        end
    endfunction

endpackage

// File: rtl/pzcorebus_protocol_monitor_fifo.sv
// Small synchronous FIFO holding burst lengths / beat counts for write matching.
// Latency: a push is visible at o_head the cycle after it is accepted.
// Backpressure: none; a push to a full FIFO without a same-cycle pop is dropped.
//
// Ports: clk, i_rst_n (async active-low), i_push/i_data, i_pop,
//        o_full, o_empty, o_head (oldest entry, valid when !o_empty).
module pzcorebus_protocol_monitor_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic             o_full,
    output logic             o_empty,
    output logic [WIDTH-1:0] o_head
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign o_full  = (count == (AW+1)'(DEPTH));
    assign o_empty = (count == '0);
    assign o_head  = mem[rd_ptr];

    // Pop is applied first, so a full FIFO can accept a push in a popping cycle.
    assign do_pop  = i_pop && !o_empty;
    assign do_push = i_push && (!o_full || do_pop);

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    // Storage needs no reset: entries are only read behind a reset pointer pair.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= i_data;
        end
    end

endmodule

// File: rtl/pzcorebus_protocol_monitor.sv
// Passive pzcorebus port monitor: stability, burst matching and outstanding checks.
// Latency: error flags set at the edge ending the offending cycle (burst compare one cycle later).
// Backpressure: none; observes only, never drives the bus.
//
// Ports: clk, i_rst_n (async active-low), i_clear (clears error status only);
//        command channel i_mcmd_*/i_scmd_accept, write data i_mdata_*/i_sdata_accept,
//        response i_sresp_*/i_mresp_accept; outputs o_error (sticky per-type flags),
//        o_error_any, o_first_error (code of first error), o_error_count (saturating).
module pzcorebus_protocol_monitor
    import pzcorebus_pkg::*;
#(
    parameter int ID_WIDTH          = 4,
    parameter int OUTSTANDING_WIDTH = 4,
    parameter int BURST_WIDTH       = 8,
    parameter int FIFO_DEPTH        = 8,
    parameter int CMD_WIDTH         = 64,
    parameter int WDATA_WIDTH       = 64,
    parameter int RESP_WIDTH        = 64,
    parameter int COUNT_WIDTH       = 16
) (
    input  logic                   clk,
    input  logic                   i_rst_n,
    input  logic                   i_clear,
    input  logic                   i_mcmd_valid,
    input  logic                   i_scmd_accept,
    input  logic                   i_mcmd_non_posted,
    input  logic                   i_mcmd_with_data,
    input  logic [ID_WIDTH-1:0]    i_mid,
    input  logic [BURST_WIDTH-1:0] i_mburst_length,
    input  logic [CMD_WIDTH-1:0]   i_mcmd_payload,
    input  logic                   i_mdata_valid,
    input  logic                   i_sdata_accept,
    input  logic                   i_mdata_last,
    input  logic [WDATA_WIDTH-1:0] i_mdata_payload,
    input  logic                   i_sresp_valid,
    input  logic                   i_mresp_accept,
    input  logic                   i_sresp_last,
    input  logic [ID_WIDTH-1:0]    i_sresp_id,
    input  logic [RESP_WIDTH-1:0]  i_sresp_payload,
    output logic [PZCOREBUS_MONITOR_ERROR_NUM-1:0] o_error,
    output logic                   o_error_any,
    output logic [2:0]             o_first_error,
    output logic [COUNT_WIDTH-1:0] o_error_count
);
    localparam int LW     = BURST_WIDTH + 1;
    localparam int NUM_ID = 1 << ID_WIDTH;

    logic cmd_ack;
    logic data_ack;
    logic resp_ack;

    assign cmd_ack  = i_mcmd_valid && i_scmd_accept;
    assign data_ack = i_mdata_valid && i_sdata_accept;
    assign resp_ack = i_sresp_valid && i_mresp_accept;

    // ---------------- handshake stability ----------------
    logic                   mcmd_stall_q;
    logic                   mdata_stall_q;
    logic                   sresp_stall_q;
    logic [CMD_WIDTH-1:0]   mcmd_payload_q;
    logic [WDATA_WIDTH-1:0] mdata_payload_q;
    logic [RESP_WIDTH-1:0]  sresp_payload_q;

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            mcmd_stall_q    <= 1'b0;
            mdata_stall_q   <= 1'b0;
            sresp_stall_q   <= 1'b0;
            mcmd_payload_q  <= '0;
            mdata_payload_q <= '0;
            sresp_payload_q <= '0;
        end else begin
            mcmd_stall_q    <= i_mcmd_valid && !i_scmd_accept;
            mdata_stall_q   <= i_mdata_valid && !i_sdata_accept;
            sresp_stall_q   <= i_sresp_valid && !i_mresp_accept;
            mcmd_payload_q  <= i_mcmd_payload;
            mdata_payload_q <= i_mdata_payload;
            sresp_payload_q <= i_sresp_payload;
        end
    end

    logic mcmd_unstable;
    logic mdata_unstable;
    logic sresp_unstable;

    // A stalled transfer must stay valid with an unchanged payload until accepted.
    assign mcmd_unstable  = mcmd_stall_q  && (!i_mcmd_valid  || (i_mcmd_payload  != mcmd_payload_q));
    assign mdata_unstable = mdata_stall_q && (!i_mdata_valid || (i_mdata_payload != mdata_payload_q));
    assign sresp_unstable = sresp_stall_q && (!i_sresp_valid || (i_sresp_payload != sresp_payload_q));

    // ---------------- burst length vs data beats ----------------
    logic          cmd_push;
    logic          data_push;
    logic          pair_pop;
    logic [LW-1:0] cmd_len;
    logic [LW-1:0] data_count_q;
    logic [LW-1:0] data_len;
    logic          cmd_full;
    logic          cmd_empty;
    logic          data_full;
    logic          data_empty;
    logic [LW-1:0] cmd_head;
    logic [LW-1:0] data_head;

    assign cmd_push  = cmd_ack && i_mcmd_with_data;
    assign data_push = data_ack && i_mdata_last;
    // A zero length field encodes the maximum burst of 2^BURST_WIDTH beats.
    assign cmd_len   = (i_mburst_length == '0) ? {1'b1, {BURST_WIDTH{1'b0}}}
                                               : {1'b0, i_mburst_length};
    assign data_len  = data_count_q + 1'b1;
    // Compare only when both sides have a completed entry; data may lead command.
    assign pair_pop  = !cmd_empty && !data_empty;

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            data_count_q <= '0;
        end else if (data_ack) begin
            data_count_q <= i_mdata_last ? '0 : data_len;
        end
    end

    pzcorebus_protocol_monitor_fifo #(
        .WIDTH (LW),
        .DEPTH (FIFO_DEPTH)
    ) u_cmd_fifo (
        .clk     (clk),
        .i_rst_n (i_rst_n),
        .i_push  (cmd_push),
        .i_data  (cmd_len),
        .i_pop   (pair_pop),
        .o_full  (cmd_full),
        .o_empty (cmd_empty),
        .o_head  (cmd_head)
    );

    pzcorebus_protocol_monitor_fifo #(
        .WIDTH (LW),
        .DEPTH (FIFO_DEPTH)
    ) u_data_fifo (
        .clk     (clk),
        .i_rst_n (i_rst_n),
        .i_push  (data_push),
        .i_data  (data_len),
        .i_pop   (pair_pop),
        .o_full  (data_full),
        .o_empty (data_empty),
        .o_head  (data_head)
    );

    logic burst_mismatch;
    logic fifo_overflow;

    assign burst_mismatch = pair_pop && (cmd_head != data_head);
    assign fifo_overflow  = (cmd_push && cmd_full && !pair_pop) ||
                            (data_push && data_full && !pair_pop);

    // ---------------- per-ID outstanding tracking ----------------
    logic [OUTSTANDING_WIDTH-1:0] outstanding_q [NUM_ID];
    logic np_inc;
    logic resp_dec;
    logic resp_unknown;
    logic outstanding_ovf;

    assign np_inc          = cmd_ack && i_mcmd_non_posted;
    assign resp_dec        = resp_ack && i_sresp_last;
    assign resp_unknown    = resp_ack && (outstanding_q[i_sresp_id] == '0);
    assign outstanding_ovf = np_inc && (outstanding_q[i_mid] == '1);

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NUM_ID; i++) begin
                outstanding_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_ID; i++) begin
                // Saturate at both ends; a simultaneous inc/dec on one ID cancels.
                if (np_inc && (i_mid == ID_WIDTH'(i)) &&
                    !(resp_dec && (i_sresp_id == ID_WIDTH'(i)))) begin
                    if (outstanding_q[i] != '1) begin
                        outstanding_q[i] <= outstanding_q[i] + 1'b1;
                    end
                end else if (resp_dec && (i_sresp_id == ID_WIDTH'(i)) &&
                             !(np_inc && (i_mid == ID_WIDTH'(i)))) begin
                    if (outstanding_q[i] != '0) begin
                        outstanding_q[i] <= outstanding_q[i] - 1'b1;
                    end
                end
            end
        end
    end

    // ---------------- error status ----------------
    logic [PZCOREBUS_MONITOR_ERROR_NUM-1:0] new_error;

    always_comb begin
        new_error = '0;
        new_error[PZCOREBUS_MCMD_UNSTABLE]        = mcmd_unstable;
        new_error[PZCOREBUS_MDATA_UNSTABLE]       = mdata_unstable;
        new_error[PZCOREBUS_BURST_MISMATCH]       = burst_mismatch;
        new_error[PZCOREBUS_SRESP_UNSTABLE]       = sresp_unstable;
        new_error[PZCOREBUS_SRESP_UNKNOWN]        = resp_unknown;
        new_error[PZCOREBUS_OUTSTANDING_OVERFLOW] = outstanding_ovf;
        new_error[PZCOREBUS_FIFO_OVERFLOW]        = fifo_overflow;
    end

    // Clear only wipes the history; an error in the clearing cycle is still recorded.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_error       <= '0;
            o_first_error <= '0;
            o_error_count <= '0;
        end else begin
            if (i_clear) begin
                o_error <= new_error;
            end else begin
                o_error <= o_error | new_error;
            end

            if ((i_clear || (o_error == '0)) && (new_error != '0)) begin
                o_first_error <= first_error_code(new_error);
            end else if (i_clear) begin
                o_first_error <= '0;
            end

            if (i_clear) begin
                o_error_count <= (new_error != '0) ? COUNT_WIDTH'(1) : '0;
            end else if ((new_error != '0) && (o_error_count != '1)) begin
                o_error_count <= o_error_count + 1'b1;
            end
        end
    end

    assign o_error_any = |o_error;

endmodule

// File: tb/tb_pzcorebus_protocol_monitor.sv
// Self-checking bench for pzcorebus_protocol_monitor: directed scenarios plus random traffic.
// Latency: n/a.
// Backpressure: n/a.
module tb_pzcorebus_protocol_monitor;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear;
    logic        mcmd_valid, scmd_accept, mcmd_non_posted, mcmd_with_data;
    logic [3:0]  mid;
    logic [7:0]  mburst_length;
    logic [63:0] mcmd_payload;
    logic        mdata_valid, sdata_accept, mdata_last;
    logic [63:0] mdata_payload;
    logic        sresp_valid, mresp_accept, sresp_last;
    logic [3:0]  sresp_id;
    logic [63:0] sresp_payload;
    logic [6:0]  error;
    logic        error_any;
    logic [2:0]  first_error;
    logic [15:0] error_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pzcorebus_protocol_monitor dut (
        .clk               (clk),
        .i_rst_n           (rst_n),
        .i_clear           (clear),
        .i_mcmd_valid      (mcmd_valid),
        .i_scmd_accept     (scmd_accept),
        .i_mcmd_non_posted (mcmd_non_posted),
        .i_mcmd_with_data  (mcmd_with_data),
        .i_mid             (mid),
        .i_mburst_length   (mburst_length),
        .i_mcmd_payload    (mcmd_payload),
        .i_mdata_valid     (mdata_valid),
        .i_sdata_accept    (sdata_accept),
        .i_mdata_last      (mdata_last),
        .i_mdata_payload   (mdata_payload),
        .i_sresp_valid     (sresp_valid),
        .i_mresp_accept    (mresp_accept),
        .i_sresp_last      (sresp_last),
        .i_sresp_id        (sresp_id),
        .i_sresp_payload   (sresp_payload),
        .o_error           (error),
        .o_error_any       (error_any),
        .o_first_error     (first_error),
        .o_error_count     (error_count)
    );

    // ---------------- reference model (transaction level) ----------------
    int unsigned m_cmdq[$];
    int unsigned m_dataq[$];
    int unsigned m_dcnt;
    int unsigned m_out[16];
    bit          m_cstall, m_dstall, m_rstall;
    logic [63:0] m_cpay, m_dpay, m_rpay;
    logic [6:0]  exp_err;
    int unsigned exp_first;
    int unsigned exp_cnt;

    always @(posedge clk or negedge rst_n) begin
        logic [6:0]  ne;
        int unsigned hc;
        int unsigned hd;
        bit          inc;
        bit          dec;
        if (!rst_n) begin
            m_cmdq.delete();
            m_dataq.delete();
            m_dcnt = 0;
            for (int i = 0; i < 16; i++) m_out[i] = 0;
            m_cstall = 0; m_dstall = 0; m_rstall = 0;
            m_cpay = '0; m_dpay = '0; m_rpay = '0;
            exp_err = '0; exp_first = 0; exp_cnt = 0;
        end else begin
            ne = '0;
            if (m_cstall && (!mcmd_valid || mcmd_payload != m_cpay)) ne[0] = 1'b1;
            if (m_dstall && (!mdata_valid || mdata_payload != m_dpay)) ne[1] = 1'b1;
            if (m_rstall && (!sresp_valid || sresp_payload != m_rpay)) ne[3] = 1'b1;
            // matching happens on entries completed in earlier cycles
            if (m_cmdq.size() > 0 && m_dataq.size() > 0) begin
                hc = m_cmdq.pop_front();
                hd = m_dataq.pop_front();
                if (hc != hd) ne[2] = 1'b1;
            end
            if (mcmd_valid && scmd_accept && mcmd_with_data) begin
                if (m_cmdq.size() >= 8) ne[6] = 1'b1;
                else m_cmdq.push_back(mburst_length == 0 ? 256 : int'(mburst_length));
            end
            if (mdata_valid && sdata_accept) begin
                if (mdata_last) begin
                    if (m_dataq.size() >= 8) ne[6] = 1'b1;
                    else m_dataq.push_back((m_dcnt + 1) % 512);
                    m_dcnt = 0;
                end else begin
                    m_dcnt = (m_dcnt + 1) % 512;
                end
            end
            inc = mcmd_valid && scmd_accept && mcmd_non_posted;
            dec = sresp_valid && mresp_accept && sresp_last;
            if (sresp_valid && mresp_accept && m_out[sresp_id] == 0) ne[4] = 1'b1;
            if (inc && m_out[mid] == 15) ne[5] = 1'b1;
            if (!(inc && dec && mid == sresp_id)) begin
                if (inc && m_out[mid] < 15) m_out[mid]++;
                if (dec && m_out[sresp_id] > 0) m_out[sresp_id]--;
            end
            m_cstall = mcmd_valid && !scmd_accept;  m_cpay = mcmd_payload;
            m_dstall = mdata_valid && !sdata_accept; m_dpay = mdata_payload;
            m_rstall = sresp_valid && !mresp_accept; m_rpay = sresp_payload;
            if (clear) begin
                exp_err = '0; exp_first = 0; exp_cnt = 0;
            end
            if (ne != '0) begin
                if (exp_err == '0) begin
                    for (int i = 6; i >= 0; i--) if (ne[i]) exp_first = i;
                end
                if (exp_cnt < 65535) exp_cnt++;
            end
            exp_err = exp_err | ne;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle();
        clear = 0;
        mcmd_valid = 0; scmd_accept = 0; mcmd_non_posted = 0; mcmd_with_data = 0;
        mid = '0; mburst_length = '0; mcmd_payload = '0;
        mdata_valid = 0; sdata_accept = 0; mdata_last = 0; mdata_payload = '0;
        sresp_valid = 0; mresp_accept = 0; sresp_last = 0; sresp_id = '0; sresp_payload = '0;
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        idle();
        rst_n = 0;
        tick(2);
        rst_n = 1;
        tick();
    endtask

    task automatic send_cmd(input bit np, input bit wd, input logic [3:0] id, input logic [7:0] len);
        mcmd_valid = 1; scmd_accept = 1; mcmd_non_posted = np; mcmd_with_data = wd;
        mid = id; mburst_length = len;
        tick();
        mcmd_valid = 0; scmd_accept = 0; mcmd_non_posted = 0; mcmd_with_data = 0;
    endtask

    task automatic send_beats(input int n, input bit with_last);
        for (int i = 0; i < n; i++) begin
            mdata_valid = 1; sdata_accept = 1;
            mdata_last = with_last && (i == n - 1);
            mdata_payload = 64'(i);
            tick();
        end
        mdata_valid = 0; sdata_accept = 0; mdata_last = 0;
    endtask

    task automatic send_resp(input logic [3:0] id);
        sresp_valid = 1; mresp_accept = 1; sresp_last = 1; sresp_id = id;
        tick();
        sresp_valid = 0; mresp_accept = 0; sresp_last = 0;
    endtask

    task automatic pulse_clear();
        clear = 1;
        tick();
        clear = 0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        do_reset();
        checks++; if (error !== 7'h00) begin errors++; $display("FAIL reset_error: got %h expected 00", error); end
        checks++; if (error_any !== 1'b0) begin errors++; $display("FAIL reset_any: got %b expected 0", error_any); end
        checks++; if (first_error !== 3'd0) begin errors++; $display("FAIL reset_first: got %0d expected 0", first_error); end
        checks++; if (error_count !== 16'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", error_count); end
    endtask

    task automatic test_write_match();
        do_reset();
        send_cmd(0, 1, 4'd0, 8'd4);
        send_beats(4, 1);
        tick(3);
        checks++; if (error !== 7'h00) begin errors++; $display("FAIL match4_error: got %h expected 00", error); end
        // a leftover FIFO entry would misalign this shorter burst
        send_cmd(0, 1, 4'd0, 8'd2);
        send_beats(2, 1);
        tick(3);
        checks++; if (error !== 7'h00) begin errors++; $display("FAIL match2_error: got %h expected 00", error); end
        checks++; if (error_count !== 16'd0) begin errors++; $display("FAIL match_count: got %0d expected 0", error_count); end
    endtask

    task automatic test_data_before_cmd();
        do_reset();
        send_beats(3, 1);
        tick();
        send_cmd(0, 1, 4'd0, 8'd4);
        checks++; if (error !== 7'h00) begin errors++; $display("FAIL early_error: got %h expected 00", error); end
        tick();
        checks++; if (error !== 7'h04) begin errors++; $display("FAIL mismatch_error: got %h expected 04", error); end
        checks++; if (first_error !== 3'd2) begin errors++; $display("FAIL mismatch_first: got %0d expected 2", first_error); end
        checks++; if (error_count !== 16'd1) begin errors++; $display("FAIL mismatch_count: got %0d expected 1", error_count); end
        checks++; if (error_any !== 1'b1) begin errors++; $display("FAIL mismatch_any: got %b expected 1", error_any); end
    endtask

    task automatic test_mcmd_unstable();
        do_reset();
        mcmd_valid = 1; scmd_accept = 0; mcmd_payload = 64'h10;
        tick();
        mcmd_payload = 64'h11;
        tick();
        checks++; if (error !== 7'h01) begin errors++; $display("FAIL mcmd_unstable_error: got %h expected 01", error); end
        checks++; if (first_error !== 3'd0) begin errors++; $display("FAIL mcmd_unstable_first: got %0d expected 0", first_error); end
        checks++; if (error_count !== 16'd1) begin errors++; $display("FAIL mcmd_unstable_count: got %0d expected 1", error_count); end
        scmd_accept = 1;
        tick();
        idle();
        tick();
    endtask

    task automatic test_resp_unknown();
        do_reset();
        send_resp(4'd5);
        checks++; if (error !== 7'h10) begin errors++; $display("FAIL unknown_error: got %h expected 10", error); end
        checks++; if (first_error !== 3'd4) begin errors++; $display("FAIL unknown_first: got %0d expected 4", first_error); end
        pulse_clear();
        send_cmd(1, 0, 4'd5, 8'd0);
        send_resp(4'd5);
        tick();
        checks++; if (error !== 7'h00) begin errors++; $display("FAIL known_resp_error: got %h expected 00", error); end
        // counter should be back at zero, so another response is unknown
        send_resp(4'd5);
        checks++; if (error !== 7'h10) begin errors++; $display("FAIL drained_error: got %h expected 10", error); end
    endtask

    task automatic test_outstanding_overflow();
        do_reset();
        for (int i = 0; i < 15; i++) send_cmd(1, 0, 4'd2, 8'd0);
        checks++; if (error !== 7'h00) begin errors++; $display("FAIL ovf15_error: got %h expected 00", error); end
        send_cmd(1, 0, 4'd2, 8'd0);
        checks++; if (error !== 7'h20) begin errors++; $display("FAIL ovf16_error: got %h expected 20", error); end
        checks++; if (first_error !== 3'd5) begin errors++; $display("FAIL ovf16_first: got %0d expected 5", first_error); end
        pulse_clear();
        for (int i = 0; i < 15; i++) send_resp(4'd2);
        checks++; if (error !== 7'h00) begin errors++; $display("FAIL ovf_drain_error: got %h expected 00", error); end
        send_resp(4'd2);
        checks++; if (error !== 7'h10) begin errors++; $display("FAIL ovf_held_error: got %h expected 10", error); end
    endtask

    task automatic test_clear_with_error();
        do_reset();
        send_resp(4'd7);
        mdata_valid = 1; sdata_accept = 0; mdata_payload = 64'hA;
        tick();
        mdata_payload = 64'hB; clear = 1;
        tick();
        clear = 0;
        checks++; if (error !== 7'h02) begin errors++; $display("FAIL clear_set_error: got %h expected 02", error); end
        checks++; if (first_error !== 3'd1) begin errors++; $display("FAIL clear_set_first: got %0d expected 1", first_error); end
        checks++; if (error_count !== 16'd1) begin errors++; $display("FAIL clear_set_count: got %0d expected 1", error_count); end
        sdata_accept = 1;
        tick();
        idle();
        tick();
    endtask

    task automatic test_async_reset();
        do_reset();
        send_resp(4'd3);
        send_cmd(0, 1, 4'd0, 8'd4);
        send_beats(2, 0);
        mdata_valid = 1; sdata_accept = 1;
        #2 rst_n = 0;
        #1;
        checks++; if (error !== 7'h00) begin errors++; $display("FAIL arst_error: got %h expected 00", error); end
        checks++; if (error_any !== 1'b0) begin errors++; $display("FAIL arst_any: got %b expected 0", error_any); end
        checks++; if (first_error !== 3'd0) begin errors++; $display("FAIL arst_first: got %0d expected 0", first_error); end
        checks++; if (error_count !== 16'd0) begin errors++; $display("FAIL arst_count: got %0d expected 0", error_count); end
        idle();
        tick();
        rst_n = 1;
        tick();
        send_beats(4, 1);
        send_cmd(0, 1, 4'd0, 8'd4);
        tick(3);
        checks++; if (error !== 7'h00) begin errors++; $display("FAIL arst_discard_error: got %h expected 00", error); end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 800; c++) begin
            clear           = ($urandom_range(0, 15) == 0);
            mcmd_valid      = $urandom_range(0, 1);
            scmd_accept     = ($urandom_range(0, 3) != 0);
            mcmd_non_posted = $urandom_range(0, 1);
            mcmd_with_data  = $urandom_range(0, 1);
            mid             = 4'($urandom_range(0, 3));
            mburst_length   = 8'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) mcmd_payload = 64'($urandom_range(0, 3));
            mdata_valid     = $urandom_range(0, 1);
            sdata_accept    = ($urandom_range(0, 3) != 0);
            mdata_last      = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 7) == 0) mdata_payload = 64'($urandom_range(0, 3));
            sresp_valid     = $urandom_range(0, 1);
            mresp_accept    = ($urandom_range(0, 3) != 0);
            sresp_last      = $urandom_range(0, 1);
            sresp_id        = 4'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) sresp_payload = 64'($urandom_range(0, 3));
            tick();
            checks++; if (error !== exp_err) begin errors++; $display("FAIL rand_error cycle %0d: got %h expected %h", c, error, exp_err); end
            checks++; if (first_error !== 3'(exp_first)) begin errors++; $display("FAIL rand_first cycle %0d: got %0d expected %0d", c, first_error, exp_first); end
            checks++; if (error_count !== 16'(exp_cnt)) begin errors++; $display("FAIL rand_count cycle %0d: got %0d expected %0d", c, error_count, exp_cnt); end
        end
        idle();
        tick();
    endtask

    initial begin
        test_reset();
        test_write_match();
        test_data_before_cmd();
        test_mcmd_unstable();
        test_resp_unknown();
        test_outstanding_overflow();
        test_clear_with_error();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
